// File: rtl/e_mdu_pkg.sv
// ============================================================================
//  Module  : mips_defs (package)
//  Purpose : MD op encoding, start-op helper and default latencies for e_mdu.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_defs;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_e;

    function automatic logic is_md_start(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/e_mdu_if.sv
// ============================================================================
//  Module  : e_mdu_if
//  Purpose : E-stage operand/op bundle into the MDU and HI/LO/stall results out.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface e_mdu_if;
    logic [3:0]  E_md_op;
    logic [31:0] E_V1;
    logic [31:0] E_V2;
    logic [31:0] E_HI;
    logic [31:0] E_LO;
    logic        E_busy;
    logic        E_MD_stall;
    logic [31:0] E_MD_out;

    modport master (
        output E_md_op, E_V1, E_V2,
        input  E_HI, E_LO, E_busy, E_MD_stall, E_MD_out
    );

    modport slave (
        input  E_md_op, E_V1, E_V2,
        output E_HI, E_LO, E_busy, E_MD_stall, E_MD_out
    );
endinterface

`default_nettype wire

// File: rtl/e_mdu_md_core.sv
// ============================================================================
//  Module  : md_core
//  Purpose : Combinational 64-bit {HI,LO} generator for mult/div ops.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module md_core
    import mips_defs::*;
(
    input  wire logic [3:0]  op_i,
    input  wire logic [31:0] a_i,
    input  wire logic [31:0] b_i,
    output logic      [63:0] res_o,
    output logic             dz_o
);

    logic signed [63:0] w_smul;
    logic        [63:0] w_umul;
    logic        [31:0] w_b_safe;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;
    logic               w_ovf;

    assign w_smul   = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign w_umul   = {32'd0, a_i} * {32'd0, b_i};
    // Zero divisor is replaced so the dividers never see it; the result is discarded anyway.
    assign w_b_safe = (b_i == 32'd0) ? 32'd1 : b_i;
    assign w_ovf    = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    assign w_sq     = w_ovf ? 32'sh8000_0000 : ($signed(a_i) / $signed(w_b_safe));
    assign w_sr     = w_ovf ? 32'sd0         : ($signed(a_i) % $signed(w_b_safe));

    always_comb begin
        res_o = 64'd0;
        dz_o  = 1'b0;
        case (op_i)
            MD_MULT:  res_o = w_smul;
            MD_MULTU: res_o = w_umul;
            MD_DIV: begin
                res_o = {w_sr, w_sq};
                dz_o  = (b_i == 32'd0);
            end
            MD_DIVU: begin
                res_o = {a_i % w_b_safe, a_i / w_b_safe};
                dz_o  = (b_i == 32'd0);
            end
            default: res_o = 64'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/e_mdu.sv
// ============================================================================
//  Module  : e_mdu
//  Purpose : E-stage multiply/divide unit with HI/LO, busy counter and stall.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module e_mdu
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  wire logic clk,
    input  wire logic reset,
    e_mdu_if.slave    bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      pend_q, pend_d;
    logic             pend_dz_q, pend_dz_d;
    logic [3:0]       pend_op_q, pend_op_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [63:0]      w_res;
    logic             w_dz;
    logic             w_start;
    logic             w_is_mult;

    md_core u_md_core (
        .op_i  (bus.E_md_op),
        .a_i   (bus.E_V1),
        .b_i   (bus.E_V2),
        .res_o (w_res),
        .dz_o  (w_dz)
    );

    assign w_start   = (state_q == S_IDLE) && is_md_start(bus.E_md_op);
    assign w_is_mult = (bus.E_md_op == MD_MULT) || (bus.E_md_op == MD_MULTU);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_dz_d = pend_dz_q;
        pend_op_d = pend_op_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    pend_d    = w_res;
                    pend_dz_d = w_dz;
                    pend_op_d = bus.E_md_op;
                    cnt_d     = w_is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    state_d   = S_BUSY;
                end else if (bus.E_md_op == MD_MTHI) begin
                    hi_d = bus.E_V1;
                end else if (bus.E_md_op == MD_MTLO) begin
                    lo_d = bus.E_V1;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Final busy cycle: commit unless the divisor was zero.
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = S_IDLE;
                    pend_op_d = MD_NONE;
                    if (!pend_dz_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_q    <= 64'd0;
            pend_dz_q <= 1'b0;
            pend_op_q <= MD_NONE;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_dz_q <= pend_dz_d;
            pend_op_q <= pend_op_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.E_HI       = hi_q;
    assign bus.E_LO       = lo_q;
    assign bus.E_busy     = (state_q == S_BUSY);
    assign bus.E_MD_stall = (state_q == S_BUSY) || w_start;
    assign bus.E_MD_out   = (bus.E_md_op == MD_MFHI) ? hi_q :
                            (bus.E_md_op == MD_MFLO) ? lo_q : 32'd0;

endmodule

`default_nettype wire

// File: doc/e_mdu.md
# e_mdu

E-stage multiply/divide unit for the P6 five-stage pipeline. It reads the operands the D/E pipeline register delivers (`E_V1`, `E_V2`) together with the decoded MD op. It runs a multi-cycle multiply or divide, holds the architectural HI/LO registers, and returns `mfhi`/`mflo` data to the E-stage result mux. It also drives `E_MD_stall` back to the hazard unit, which holds D and flushes E while an MD instruction must wait.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`.

Ports:
- `clk` input 1: single clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high.
- `E_md_op` input 4: decoded MD operation for the instruction currently in E (encoding in package).
- `E_V1` input 32: rs operand (forwarded).
- `E_V2` input 32: rt operand (forwarded).
- `E_HI` output 32: HI register.
- `E_LO` output 32: LO register.
- `E_busy` output 1: operation in progress.
- `E_MD_stall` output 1: registered `E_busy`, OR'd combinationally with "start decoded this cycle", to the hazard unit.
- `E_MD_out` output 32: combinational; HI for MFHI, LO for MFLO, 0 otherwise.

## Operation
- Reset values: `E_HI`=0, `E_LO`=0, `E_busy`=0, internal counter=0, pending result=0, pending op=NONE.
- States: IDLE (counter=0) and BUSY (counter>0).
- Start condition: IDLE and op ∈ {MULT, MULTU, DIV, DIVU}.
  - On start, the result is computed from that cycle's `E_V1`/`E_V2` and latched into a pending 64-bit register.
  - The counter loads with `MULT_CYCLES` or `DIV_CYCLES`.
  - Transition to BUSY.
- BUSY: the counter decrements each cycle. On the edge where the counter goes 1→0, the pending {HI, LO} commits and the state returns to IDLE.
- Arithmetic:
  - MULT: {HI, LO} = signed 32×32→64.
  - MULTU: {HI, LO} = unsigned 32×32→64.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero: the op still occupies `DIV_CYCLES`; HI/LO are left unchanged at commit.
- MTHI / MTLO: write `E_V1` into HI / LO at the next edge, in IDLE only. In BUSY they are ignored; the hazard unit must stall them, and this is a bench assertion.
- MFHI / MFLO: combinational read of the current `E_HI` / `E_LO`.
  - The hazard unit stalls them while `E_MD_stall`=1.
  - In IDLE the read returns committed values.
- Start-class op while BUSY: ignored, with no restart and no result change.
- Reset mid-operation: abort. Counter, pending result, HI and LO all clear next edge, and the pending commit never occurs.
- Simultaneous events:
  - Reset wins over everything.
  - A commit edge and a new start cannot coincide, because start requires IDLE.
  - The cycle right after a commit is IDLE and accepts a new start.

## Timing
- Start presented in cycle T: `E_MD_stall`=1 combinationally in T.
- `E_busy`=1 in cycles T+1 … T+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
- HI/LO hold new values from T+N+1; `E_busy`=0 in T+N+1.
- MTHI/MTLO presented in cycle T: the new value is visible from T+1.
- `E_MD_out` has zero latency from `E_md_op` and HI/LO.
- The op may be held in E for multiple cycles by an upstream stall. Only the first IDLE cycle starts an operation. Re-presenting the same op after commit starts a new one, so the hazard unit flushes E on MD stall.

## Structure
- Shared package `mips_defs`:
  - MD op constants: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
  - Helper `is_md_start(op)`.
  - Default cycle counts.
- One sub-module, `md_core`: purely combinational 64-bit result generator (signed/unsigned mult, div, divide-by-zero flag). `e_mdu` owns the counter, pending register, HI/LO and the stall logic.
- Instantiated in the CPU top next to the ALU, fed from `E_Reg` outputs. `E_MD_out` feeds the E result mux. `E_MD_stall` feeds the hazard unit.

## Test plan
- Reset, then MULT with V1=0xFFFFFFFF, V2=2. `E_busy` is high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands gives HI=0x00000001, LO=0xFFFFFFFE.
- DIV with V1=0xFFFFFFF9 (-7), V2=2. Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 gives LO=3, HI=1.
- MTHI 0x12345678 then DIVU 5/0. After 10 busy cycles, HI=0x12345678 and LO is unchanged.
- MULT started, then a DIV op presented in busy cycle 2. The DIV is ignored, busy ends after the original 5 cycles, and the MULT result is committed.
- MULT started, then `reset` asserted in busy cycle 3. The next cycle shows busy=0, HI=LO=0, and no commit afterwards.
- MTLO 0xDEADBEEF in IDLE, then MFLO the next cycle gives `E_MD_out`=0xDEADBEEF. The `E_MD_stall` combinational assertion in the start cycle is also checked.
